// File: rtl/alu_pkg.sv
// Shared types for the ALU issue unit: datapath widths, FSM states, command record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_W = 8;
    localparam int SEL_W = 4;

    // Issue sequencer states: waiting for work, ALU settling, result on offer
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // One queued ALU command
    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [SEL_W-1:0] sel;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of WIDTH bits, registered count.
// Latency: a pushed entry is visible on o_dat/o_empty the cycle after the push (no bypass).
// Backpressure: pushes while full are dropped even if a pop happens that cycle; pops while empty are ignored.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Full gates the push regardless of a simultaneous pop, so a full slot is never overwritten
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_dat   = r_mem[r_rd_ptr];

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents need no reset because occupancy is tracked separately
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_dat;
        end
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue front end for the 8-bit combinational ALU: queues commands, drives registered ALU inputs, captures results.
// Latency: accept at edge k -> o_alu_* at k+1 -> o_res_valid at k+2; at most one result every 2 cycles.
// Backpressure: o_res_* held until i_res_ready; o_cmd_ready drops when the queue is full. Optional ALU_ISSUE_FLAGS_EN adds o_res_zero/o_carry_count.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_cmd_valid,
    output logic             o_cmd_ready,
    input  logic [ALU_W-1:0] i_cmd_a,
    input  logic [ALU_W-1:0] i_cmd_b,
    input  logic [SEL_W-1:0] i_cmd_sel,
    output logic [ALU_W-1:0] o_alu_a,
    output logic [ALU_W-1:0] o_alu_b,
    output logic [SEL_W-1:0] o_alu_sel,
    input  logic [ALU_W-1:0] i_alu_out,
    input  logic             i_alu_carry,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [ALU_W-1:0] o_res_data,
    output logic             o_res_carry,
    output logic [SEL_W-1:0] o_res_sel
`ifdef ALU_ISSUE_FLAGS_EN
    ,
    output logic             o_res_zero,
    output logic [7:0]       o_carry_count
`endif
);

    state_t           r_state;
    cmd_t             r_alu;
    logic             r_res_valid;
    logic [ALU_W-1:0] r_res_data;
    logic             r_res_carry;
    logic [SEL_W-1:0] r_res_sel;
`ifdef ALU_ISSUE_FLAGS_EN
    logic             r_res_zero;
    logic [7:0]       r_carry_count;
`endif

    cmd_t             w_cmd_in;
    cmd_t             w_fifo_dat;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic             w_pop;

    assign w_cmd_in.a   = i_cmd_a;
    assign w_cmd_in.b   = i_cmd_b;
    assign w_cmd_in.sel = i_cmd_sel;

    // A new command is taken whenever the ALU stage is free or is being freed by a result handshake
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && i_res_ready));

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_cmd_valid),
        .i_dat   (w_cmd_in),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    // Issue sequencer: load ALU inputs, wait one settle cycle, capture, hold until consumed
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_alu         <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_carry   <= 1'b0;
            r_res_sel     <= '0;
`ifdef ALU_ISSUE_FLAGS_EN
            r_res_zero    <= 1'b1;
            r_carry_count <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_alu   <= w_fifo_dat;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res_data  <= i_alu_out;
                    r_res_carry <= i_alu_carry;
                    r_res_sel   <= r_alu.sel;
`ifdef ALU_ISSUE_FLAGS_EN
                    r_res_zero  <= (i_alu_out == '0);
`endif
                    r_res_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
`ifdef ALU_ISSUE_FLAGS_EN
                        if (r_res_carry && (r_carry_count != 8'hFF)) begin
                            r_carry_count <= r_carry_count + 8'd1;
                        end
`endif
                        if (!w_fifo_empty) begin
                            r_alu   <= w_fifo_dat;
                            r_state <= ST_EXEC;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_cmd_ready   = !w_fifo_full;
    assign o_alu_a       = r_alu.a;
    assign o_alu_b       = r_alu.b;
    assign o_alu_sel     = r_alu.sel;
    assign o_res_valid   = r_res_valid;
    assign o_res_data    = r_res_data;
    assign o_res_carry   = r_res_carry;
    assign o_res_sel     = r_res_sel;
`ifdef ALU_ISSUE_FLAGS_EN
    assign o_res_zero    = r_res_zero;
    assign o_carry_count = r_carry_count;
`endif

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Command-issue front end for the 8-bit combinational ALU. Buffers operand/opcode commands in a small FIFO, drives the ALU's A/B/select inputs from registers, captures the ALU result and carry one cycle later, and presents the result on a valid/ready output port. It sits directly upstream of the ALU and also consumes what the ALU produces, so the datapath is fully registered on both sides.

## Interface
- `DEPTH`, 4: command FIFO depth; power of two, at least 2.
- `clk`  in  1  single clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  FIFO can accept (`!full`).
- `cmd_a`, `cmd_b`  in  8  operands.
- `cmd_sel`  in  4  ALU opcode.
- `alu_a`, `alu_b`  out  8  registered operands to ALU.
- `alu_sel`  out  4  registered opcode to ALU.
- `alu_out`  in  8  ALU result (combinational from `alu_*`).
- `alu_carry`  in  1  ALU carry out.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts result.
- `res_data`  out  8  captured ALU result.
- `res_carry`  out  1  captured carry.
- `res_sel`  out  4  opcode echo of the captured result.
- `res_zero`  out  1  `res_data == 0` (only with `ALU_ISSUE_FLAGS_EN`).
- `carry_count`  out  8  saturating count of accepted results with carry set (only with `ALU_ISSUE_FLAGS_EN`).

## Operation
- Push: `cmd_valid && cmd_ready` writes {a,b,sel} to the FIFO. There is no bypass, so an accepted command is visible only on the next cycle.
- FSM states are IDLE, EXEC and HOLD.
  - IDLE: if the FIFO is non-empty, pop it, load `alu_a/b/sel`, and go to EXEC. Otherwise stay.
  - EXEC: the ALU settles for one full cycle. At the edge, capture `alu_out`, `alu_carry` and `alu_sel` into `res_*`, set `res_valid`, and go to HOLD.
  - HOLD: `res_*` and `alu_*` stay stable. On `res_ready`, clear `res_valid`.
    - If the FIFO is non-empty, pop in the same cycle, load `alu_*`, and go to EXEC.
    - Otherwise go to IDLE.
- Results leave in command order. No commands are dropped or reordered.
- Full FIFO: `cmd_ready` is 0, and a push is ignored even if a pop happens in the same cycle. The FIFO never pushes and pops a full slot in the same cycle.
- Empty FIFO with a push in the same cycle as IDLE: the pop happens on the following cycle.
- Reset (asynchronous, any state): FIFO pointers and count go to 0, the FSM goes to IDLE, and all in-flight and queued commands are discarded.

## Timing
- Reset values:
  - `cmd_ready` = 1.
  - `alu_a`, `alu_b`, `alu_sel` = 0.
  - `res_valid`, `res_data`, `res_carry`, `res_sel` = 0.
  - `res_zero` = 1 (since `res_data` = 0).
  - `carry_count` = 0.
- Latency: command accepted at edge k → `alu_*` valid after edge k+1 → `res_valid` high after edge k+2.
- Throughput: at most one result per 2 cycles. `res_valid` is low for at least one cycle between consecutive results.
- `res_*` change only at the edge that sets `res_valid`.
- `res_valid` is never deasserted without a `res_ready` handshake, except by reset.
- Capacity: `DEPTH` queued commands plus 1 in EXEC/HOLD.

## Configuration
- `ALU_ISSUE_FLAGS_EN` defined:
  - `res_zero` and `carry_count` ports exist.
  - `res_zero` is captured together with `res_data`.
  - `carry_count` increments on each `res_valid && res_ready` where `res_carry` = 1, and saturates at 255.
- `ALU_ISSUE_FLAGS_EN` undefined: both ports and their logic are absent. All other behaviour is identical.

## Structure
- Package `alu_pkg` holds:
  - `ALU_W` = 8 and `SEL_W` = 4.
  - The FSM state enum.
  - The packed command struct {a, b, sel}.
- Sub-module `alu_cmd_fifo`: synchronous FIFO, parameterised by `DEPTH` and width. Ports: push, pop, full, empty, data in and data out.
- FSM and result registers live in the top level. The ALU itself is instantiated outside this block.

## Test plan
- Single command, A=5, B=2, sel=0 (add), `res_ready`=1:
  - `alu_a`=5 and `alu_b`=2 one cycle after accept.
  - `res_valid` two cycles after accept, with `res_data`=7, `res_carry`=0, `res_sel`=0.
- Opcode sweep, A=5, B=2, sel 0..15 back-to-back, `res_ready`=1: 16 results in order, `res_sel` = 0..15, spaced every 2 cycles, each `res_data` matching the ALU model.
- Fill, `DEPTH`=4, `res_ready`=0, 7 commands offered: 5 accepted, then `cmd_ready`=0. Raising `res_ready` drains all 5 in order.
- Backpressure, `res_ready` held low 10 cycles in HOLD: `res_data`, `res_carry`, `res_sel` and `alu_*` are unchanged throughout. The result is accepted exactly once.
- Reset mid-operation, `rst_n` low in HOLD with 3 commands queued:
  - All outputs take reset values immediately, without waiting for a clock edge.
  - After release, no `res_valid` appears until a new command is pushed.
- Flags (`ALU_ISSUE_FLAGS_EN`):
  - A=0, B=0, add → `res_zero`=1.
  - A=200, B=100, add → `res_data`=44, `res_carry`=1, `carry_count` goes 0→1 after the handshake.
